// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared definitions for the I2S receiver: default sample
//                width, slot bit-counter width and receiver FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package i2s_pkg;

  // Default sample width per channel
  localparam int c_data_w = 16;

  // Slot bit counter width (saturates at 2**c_cnt_w - 1)
  localparam int c_cnt_w = 6;

  // Receiver FSM: SYNC waits for the first ws 1->0 change edge
  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff
//  Description : N-stage flip-flop synchronizer with asynchronous reset.
//  Ports       : clk  - destination clock
//                rst  - asynchronous active-high reset (clears all stages)
//                d    - asynchronous input
//                q    - synchronized output
//  Revision    : 1.0  initial release
// ============================================================================
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] r_stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[N-2:0], d};
    end
  end

  assign q = r_stage[N-1];

endmodule
`default_nettype wire

// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx
//  Description : Philips I2S slave receiver. Oversamples bclk/ws/d with the
//                system clock, assembles left/right slots MSB first and
//                presents complete frames with a valid/ready handshake.
//  Ports       : clk, rst          - system clock, async active-high reset
//                bclk, ws, d       - I2S bus from external master
//                L, R              - last completed frame
//                valid, ready      - frame handshake
//                overrun           - pulse: unconsumed frame overwritten
//                err               - pulse: slot shorter than DATA_W
//  Revision    : 1.0  initial release
// ============================================================================
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_W      = c_data_w,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bclk,
  input  logic              ws,
  input  logic              d,
  output logic [DATA_W-1:0] L,
  output logic [DATA_W-1:0] R,
  output logic              valid,
  input  logic              ready,
  output logic              overrun,
  output logic              err
);

  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DATA_W);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_W - 1);

  // All three pins go through identical chains so they stay aligned
  logic [2:0] w_pins_raw;
  logic [2:0] w_pins_sync;

  assign w_pins_raw = {bclk, ws, d};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    sync_ff #(.N(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (w_pins_raw[gi]),
      .q   (w_pins_sync[gi])
    );
  end

  logic w_bclk_s;
  logic w_ws_s;
  logic w_d_s;

  assign w_bclk_s = w_pins_sync[2];
  assign w_ws_s   = w_pins_sync[1];
  assign w_d_s    = w_pins_sync[0];

  state_t              r_state;
  logic                r_bclk_prev;
  logic                r_ws_prev;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_left_word;
  logic                r_left_bad;

  logic                w_rise;
  logic                w_ws_chg;
  logic                w_ws_fall;
  logic                w_shift_en;
  logic                w_len_ok;
  logic [DATA_W-1:0]   w_shift_next;
  logic [DATA_W-1:0]   w_word;

  assign w_rise       = w_bclk_s & ~r_bclk_prev;
  assign w_ws_chg     = w_ws_s ^ r_ws_prev;
  assign w_ws_fall    = w_ws_chg & ~w_ws_s;
  assign w_shift_en   = (r_cnt < c_full);
  // r_cnt counts bits before the current one; the change edge carries the
  // slot's final bit, so the slot is full when DATA_W-1 bits came before it
  assign w_len_ok     = (r_cnt >= c_last);
  assign w_shift_next = {r_shift[DATA_W-2:0], w_d_s};
  // Word as it stands including the bit sampled at the closing edge
  assign w_word       = w_shift_en ? w_shift_next : r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_SYNC;
      r_bclk_prev <= 1'b0;
      r_ws_prev   <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_left_word <= '0;
      r_left_bad  <= 1'b0;
      L           <= '0;
      R           <= '0;
      valid       <= 1'b0;
      overrun     <= 1'b0;
      err         <= 1'b0;
    end else begin
      r_bclk_prev <= w_bclk_s;
      overrun     <= 1'b0;
      err         <= 1'b0;

      // A frame loaded later in this block overrides the consume clear
      if (valid && ready) begin
        valid <= 1'b0;
      end

      if (w_rise) begin
        r_ws_prev <= w_ws_s;
        case (r_state)
          ST_SYNC: begin
            r_cnt   <= '0;
            r_shift <= '0;
            if (w_ws_fall) begin
              r_state <= ST_LEFT;
            end
          end

          ST_LEFT, ST_RIGHT: begin
            if (w_ws_chg) begin
              r_cnt <= '0;
              if (r_state == ST_LEFT) begin
                r_left_word <= w_word;
                r_left_bad  <= ~w_len_ok;
                err         <= ~w_len_ok;
                r_state     <= ST_RIGHT;
              end else begin
                r_state <= ST_LEFT;
                if (!w_len_ok) begin
                  err <= 1'b1;
                end else if (!r_left_bad) begin
                  L       <= r_left_word;
                  R       <= w_word;
                  valid   <= 1'b1;
                  overrun <= valid & ~ready;
                end
              end
            end else begin
              if (w_shift_en) begin
                r_shift <= w_shift_next;
              end
              if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end

          default: r_state <= ST_SYNC;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_rx
//  Description : Self-checking bench for i2s_rx (DATA_W=16, bclk = clk/8).
//                Frames are pushed to a scoreboard when sent and popped when
//                the receiver hands them over (valid && ready).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2s_rx;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bclk = 1'b0;
  logic          ws = 1'b1;
  logic          d = 1'b0;
  logic [DW-1:0] L;
  logic [DW-1:0] R;
  logic          valid;
  logic          ready = 1'b1;
  logic          overrun;
  logic          err;

  i2s_rx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bclk    (bclk),
    .ws      (ws),
    .d       (d),
    .L       (L),
    .R       (R),
    .valid   (valid),
    .ready   (ready),
    .overrun (overrun),
    .err     (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_err  = 0;
  int n_ovr  = 0;
  logic [31:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer and pulse counters
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) n_ovr++;
      if (err) n_err++;
      if (valid && ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_frame", {L, R}, 32'hxxxxxxxx);
        end else begin
          logic [31:0] e;
          e = sb_q.pop_front();
          chk("frame_LR", {L, R}, e);
        end
      end
    end
  end

  // One bit period: data changes with bclk low, sampled on bclk rise
  task automatic send_bit(input logic ws_v, input logic d_v);
    bclk = 1'b0;
    ws   = ws_v;
    d    = d_v;
    #40;
    bclk = 1'b1;
    #40;
  endtask

  // Slot of n bits; ws toggles on the slot's final bit (one-bit delay)
  task automatic send_slot(input logic [DW-1:0] word, input int n,
                           input logic pad, input logic is_left);
    logic ws_v;
    logic d_v;
    for (int k = 0; k < n; k++) begin
      ws_v = is_left ? (k == n - 1) : (k != n - 1);
      d_v  = (k < DW) ? word[DW-1-k] : pad;
      send_bit(ws_v, d_v);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] lw, input logic [DW-1:0] rw,
                            input int nl, input int nr, input logic pad);
    send_slot(lw, nl, pad, 1'b1);
    send_slot(rw, nr, pad, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int            nl;
    int            nr;
    logic          pad;
    int            exp_err;
    logic          exp_frame;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int e0;
    int o0;

    vecs[0] = '{16'h1234, 16'hABCD, 16, 16, 1'b0, 0, 1'b1};
    vecs[1] = '{16'h8001, 16'h7FFE, 32, 32, 1'b1, 0, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 16, 16, 1'b0, 0, 1'b1};
    vecs[3] = '{16'h5A5A, 16'hA5A5, 17, 20, 1'b0, 0, 1'b1};
    vecs[4] = '{16'hDEAD, 16'hBEEF,  8, 16, 1'b0, 1, 1'b0};
    vecs[5] = '{16'h0F0F, 16'hF0F0, 16, 16, 1'b1, 0, 1'b1};
    vecs[6] = '{16'h1357, 16'h2468, 16, 15, 1'b0, 1, 1'b0};
    vecs[7] = '{16'hC3C3, 16'h3C3C, 16, 16, 1'b0, 0, 1'b1};
    vecs[8] = '{16'h7777, 16'h8888, 15, 16, 1'b0, 1, 1'b0};
    vecs[9] = '{16'h0001, 16'h8000, 64, 16, 1'b1, 0, 1'b1};

    // Reset state
    idle(4);
    chk("rst_L", {16'h0, L}, 32'h0);
    chk("rst_R", {16'h0, R}, 32'h0);
    chk("rst_valid", {31'h0, valid}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    rst = 1'b0;
    idle(4);

    // Capture starts mid-right-slot: tail of a right slot, then change edge
    for (int k = 0; k < 5; k++) send_bit(1'b1, k[0]);
    send_bit(1'b0, 1'b1);
    idle(12);
    chk("sync_no_valid", {31'h0, valid}, 32'h0);
    chk("sync_no_frame", sb_q.size(), 32'd0);

    // Table-driven frames with ready held high
    o0 = n_ovr;
    for (int i = 0; i < 10; i++) begin
      e0 = n_err;
      if (vecs[i].exp_frame) sb_q.push_back({vecs[i].l, vecs[i].r});
      send_frame(vecs[i].l, vecs[i].r, vecs[i].nl, vecs[i].nr, vecs[i].pad);
      idle(12);
      chk($sformatf("vec%0d_err", i), n_err - e0, vecs[i].exp_err);
      chk($sformatf("vec%0d_consumed", i), sb_q.size(), 32'd0);
    end
    chk("no_overrun_ready_high", n_ovr - o0, 32'd0);

    // Overrun: two frames with ready low, second overwrites first
    ready = 1'b0;
    o0 = n_ovr;
    send_frame(16'h1111, 16'h2222, 16, 16, 1'b0);
    idle(12);
    chk("ovr_first_valid", {31'h0, valid}, 32'h1);
    chk("ovr_first_L", {16'h0, L}, {16'h0, 16'h1111});
    send_frame(16'h3333, 16'h4444, 16, 16, 1'b0);
    idle(12);
    chk("ovr_pulses", n_ovr - o0, 32'd1);
    chk("ovr_held_LR", {L, R}, 32'h3333_4444);
    idle(40);
    chk("ovr_still_valid", {31'h0, valid}, 32'h1);
    chk("ovr_still_LR", {L, R}, 32'h3333_4444);
    sb_q.push_back(32'h3333_4444);
    ready = 1'b1;
    idle(4);
    chk("ovr_consumed", sb_q.size(), 32'd0);
    chk("ovr_valid_cleared", {31'h0, valid}, 32'h0);

    // Reset mid-left-slot while a frame is held
    ready = 1'b0;
    send_frame(16'h9999, 16'h6666, 16, 16, 1'b0);
    idle(12);
    chk("pre_rst_valid", {31'h0, valid}, 32'h1);
    for (int k = 0; k < 6; k++) send_bit(1'b0, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'h0, valid}, 32'h0);
    chk("async_rst_LR", {L, R}, 32'h0);
    idle(3);
    rst = 1'b0;
    ready = 1'b1;
    // Rest of the interrupted frame must be discarded
    for (int k = 6; k < 16; k++) send_bit(k == 15, 1'b1);
    send_slot(16'h5555, 16, 1'b0, 1'b0);
    idle(12);
    chk("post_rst_partial_dropped", {31'h0, valid}, 32'h0);
    sb_q.push_back(32'h600D_CAFE);
    send_frame(16'h600D, 16'hCAFE, 16, 16, 1'b0);
    idle(12);
    chk("post_rst_frame_consumed", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
